// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block with debounced inputs.
//   - APB data/address widths
//   - register byte offsets
//   - per-pin interrupt mode encoding
//   - helpers for address legality and per-pin event qualification
package gpio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] OFF_IN      = 8'h00;
  localparam logic [ADDR_W-1:0] OFF_OUT     = 8'h04;
  localparam logic [ADDR_W-1:0] OFF_SET     = 8'h08;
  localparam logic [ADDR_W-1:0] OFF_CLR     = 8'h0C;
  localparam logic [ADDR_W-1:0] OFF_DIR     = 8'h10;
  localparam logic [ADDR_W-1:0] OFF_IE      = 8'h14;
  localparam logic [ADDR_W-1:0] OFF_MODE_LO = 8'h18;
  localparam logic [ADDR_W-1:0] OFF_MODE_HI = 8'h1C;
  localparam logic [ADDR_W-1:0] OFF_IFG     = 8'h20;
  localparam logic [ADDR_W-1:0] OFF_DBCFG   = 8'h24;
  localparam logic [ADDR_W-1:0] OFF_DBEN    = 8'h28;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } gpio_mode_e;

  // Word-aligned and inside the contiguous register window.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= OFF_DBEN);
  endfunction

  // cur is the filtered pin, prev its value one cycle earlier.
  function automatic logic mode_hit(input gpio_mode_e m, input logic cur,
                                    input logic prev);
    logic hit;
    case (m)
      MODE_RISE: hit = cur & ~prev;
      MODE_FALL: hit = ~cur & prev;
      MODE_BOTH: hit = cur ^ prev;
      default:   hit = cur;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin input conditioning: synchroniser chain followed by a debounce
// filter. The filter output only follows the synchronised pin after it has
// differed from the current filtered value for thr_i consecutive cycles.
// Ports:
//   clk_i  - clock          rst_i  - async active-high reset
//   pin_i  - raw async pin  thr_i  - debounce threshold T
//   en_i   - debounce enable (0 = bypass, filter follows sync every cycle)
//   clr_i  - clear the debounce counter
//   filt_o - filtered pin value
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pin_i,
  input  logic [DB_W-1:0] thr_i,
  input  logic            en_i,
  input  logic            clr_i,
  output logic            filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync, bypass;

  assign sync   = sync_q[SYNC_STAGES-1];
  // A threshold of 0 or 1 behaves as no filtering at all.
  assign bypass = !en_i || (thr_i <= DB_W'(1));
  assign filt_o = filt_q;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (bypass) begin
      filt_d = sync;
      cnt_d  = '0;
    end else if (clr_i || (sync == filt_q)) begin
      cnt_d = '0;
    end else if (cnt_q == thr_i - DB_W'(1)) begin
      filt_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/gpio_apb_db.sv
// APB3 GPIO controller with per-pin synchronisers, optional debounce and
// edge/level interrupt flags.
// Ports:
//   PCLK, PRESET            - clock, async active-high reset
//   PSEL/PENABLE/PWRITE     - APB control; PADDR byte address; PWDATA data
//   PRDATA/PREADY/PSLVERR   - APB response (zero wait state)
//   gpio_in                 - asynchronous pin inputs
//   gpio_out/gpio_oe        - output values / output enables (1 = drive)
//   irq                     - OR of enabled interrupt flags
module gpio_apb_db
  import gpio_pkg::*;
#(
  parameter int unsigned NGPIO       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NGPIO-1:0]  gpio_in,
  output logic [NGPIO-1:0]  gpio_out,
  output logic [NGPIO-1:0]  gpio_oe,
  output logic              irq
);

  logic [NGPIO-1:0]   out_q, out_d, dir_q, dir_d, ie_q, ie_d;
  logic [NGPIO-1:0]   ifg_q, ifg_d, dben_q, dben_d;
  logic [NGPIO-1:0]   filt, filt_prev_q, hw_set, ifg_clr;
  logic [2*NGPIO-1:0] mode_q, mode_d;
  logic [DB_W-1:0]    dbcfg_q, dbcfg_d;
  logic [63:0]        mode64, mode_w64;
  logic               access, err, wr_ok, db_clr;
  logic [DATA_W-1:0]  rdata;

  // MODE is held packed at 2 bits/pin and viewed as a 64-bit LO/HI pair.
  assign mode64 = 64'(mode_q);

  assign access = PSEL & PENABLE;
  assign err    = access & (!addr_ok(PADDR) | (PWRITE & (PADDR == OFF_IN)));
  assign wr_ok  = access & PWRITE & !err;

  for (genvar g = 0; g < NGPIO; g++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_W       (DB_W)
    ) u_db (
      .clk_i (PCLK),
      .rst_i (PRESET),
      .pin_i (gpio_in[g]),
      .thr_i (dbcfg_q),
      .en_i  (dben_q[g]),
      .clr_i (db_clr),
      .filt_o(filt[g])
    );
  end

  always_comb begin
    hw_set = '0;
    for (int unsigned i = 0; i < NGPIO; i++) begin
      hw_set[i] = mode_hit(gpio_mode_e'(mode_q[2*i +: 2]), filt[i], filt_prev_q[i]);
    end
  end

  always_comb begin
    out_d    = out_q;
    dir_d    = dir_q;
    ie_d     = ie_q;
    mode_w64 = mode64;
    dbcfg_d  = dbcfg_q;
    dben_d   = dben_q;
    ifg_clr  = '0;
    db_clr   = 1'b0;
    if (wr_ok) begin
      case (PADDR)
        OFF_OUT:     out_d    = PWDATA[NGPIO-1:0];
        OFF_SET:     out_d    = out_q | PWDATA[NGPIO-1:0];
        OFF_CLR:     out_d    = out_q & ~PWDATA[NGPIO-1:0];
        OFF_DIR:     dir_d    = PWDATA[NGPIO-1:0];
        OFF_IE:      ie_d     = PWDATA[NGPIO-1:0];
        OFF_MODE_LO: mode_w64 = {mode64[63:32], PWDATA};
        OFF_MODE_HI: mode_w64 = {PWDATA, mode64[31:0]};
        OFF_IFG:     ifg_clr  = PWDATA[NGPIO-1:0];
        OFF_DBCFG: begin
          dbcfg_d = PWDATA[DB_W-1:0];
          db_clr  = 1'b1;
        end
        OFF_DBEN: begin
          dben_d = PWDATA[NGPIO-1:0];
          db_clr = 1'b1;
        end
        default: ;
      endcase
    end
    mode_d = mode_w64[2*NGPIO-1:0];
    // Hardware set is applied after the W1C so a coincident event wins.
    ifg_d  = (ifg_q & ~ifg_clr) | hw_set;
  end

  always_comb begin
    rdata = '0;
    case (PADDR)
      OFF_IN:      rdata = DATA_W'(filt);
      OFF_OUT:     rdata = DATA_W'(out_q);
      OFF_DIR:     rdata = DATA_W'(dir_q);
      OFF_IE:      rdata = DATA_W'(ie_q);
      OFF_MODE_LO: rdata = mode64[31:0];
      OFF_MODE_HI: rdata = mode64[63:32];
      OFF_IFG:     rdata = DATA_W'(ifg_q);
      OFF_DBCFG:   rdata = DATA_W'(dbcfg_q);
      OFF_DBEN:    rdata = DATA_W'(dben_q);
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      out_q       <= '0;
      dir_q       <= '0;
      ie_q        <= '0;
      mode_q      <= '0;
      ifg_q       <= '0;
      dbcfg_q     <= '0;
      dben_q      <= '0;
      filt_prev_q <= '0;
    end else begin
      out_q       <= out_d;
      dir_q       <= dir_d;
      ie_q        <= ie_d;
      mode_q      <= mode_d;
      ifg_q       <= ifg_d;
      dbcfg_q     <= dbcfg_d;
      dben_q      <= dben_d;
      filt_prev_q <= filt;
    end
  end

  // Response outputs are forced quiet while reset is held.
  assign PRDATA   = (PSEL && !err && !PRESET) ? rdata : '0;
  assign PSLVERR  = err & !PRESET;
  assign PREADY   = 1'b1;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(ifg_q & ie_q);

endmodule

// File: doc/gpio_apb_db.md
GPIO_APB_DB -- requirements
Module: gpio_apb_db

Interface
REQ-001 The block SHALL have parameter NGPIO, default 32, giving the pin count (legal 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal 2..3).
REQ-003 The block SHALL have parameter DB_W, default 8, giving the debounce counter width (legal 1..16).
REQ-004 The block SHALL have ports, one per line:
 PCLK  in  1  single clock, all flops rising-edge;
 PRESET  in  1  reset, asynchronous, active-high;
 PSEL, PENABLE, PWRITE  in  1  APB control;
 PADDR  in  8  byte address;
 PWDATA  in  32  write data;
 PRDATA  out  32  read data;
 PREADY  out  1  transfer ready;
 PSLVERR  out  1  transfer error;
 gpio_in  in  NGPIO  asynchronous pin inputs;
 gpio_out  out  NGPIO  output values;
 gpio_oe  out  NGPIO  output enables, 1 = drive;
 irq  out  1  interrupt.

Function
REQ-005 Register map: 0x00 IN (RO, filtered pins); 0x04 OUT (RW); 0x08 SET (WO, W1S into OUT); 0x0C CLR (WO, W1C into OUT); 0x10 DIR (RW); 0x14 IE (RW); 0x18 MODE_LO (RW, 2 bits per pin, pins 0..15); 0x1C MODE_HI (RW, pins 16..31); 0x20 IFG (RW1C); 0x24 DBCFG (RW, bits [DB_W-1:0]); 0x28 DBEN (RW, per-pin debounce enable).
REQ-006 PREADY SHALL be 1 at all times; writes SHALL commit on the PSEL&PENABLE&PWRITE edge; PRDATA SHALL be valid combinationally during the access phase.
REQ-007 PSLVERR SHALL assert in the access phase for an unmapped address, PADDR[1:0] != 0, or a write to IN; an erroring write SHALL change no state.
REQ-008 Register bits at or above NGPIO (and DBCFG above DB_W) SHALL read 0 and ignore writes; SET and CLR SHALL read 0.
REQ-009 gpio_out SHALL equal OUT and gpio_oe SHALL equal DIR, with no added latency.
REQ-010 Each pin SHALL pass through SYNC_STAGES flops to give sync[i].
REQ-011 With DBEN[i]=0 or DBCFG<=1, filt[i] SHALL load sync[i] every cycle.
REQ-012 Otherwise, with T=DBCFG, cnt[i] SHALL clear when sync[i]==filt[i] and increment when they differ; when they differ and cnt[i]==T-1, filt[i] SHALL load sync[i] and cnt[i] SHALL clear.
REQ-013 A glitch shorter than T cycles SHALL NOT change filt; pin-to-IN latency SHALL be SYNC_STAGES+T cycles, with T=1 in bypass.
REQ-014 Any write to DBCFG or DBEN SHALL clear all counters.
REQ-015 MODE encoding: 00 rising, 01 falling, 10 both edges, 11 level-high; an edge is filt versus a registered copy filt_d.
REQ-016 IFG[i] SHALL set on the cycle after the qualifying event; in level mode it SHALL set every cycle filt[i]=1, so it re-asserts after a clear.
REQ-017 A W1C to IFG and a hardware set on the same bit in the same cycle SHALL leave the bit 1 (set wins).
REQ-018 IFG SHALL be recorded regardless of IE.
REQ-019 irq SHALL equal |(IFG & IE) combinationally from registers.
REQ-020 SET/CLR SHALL be read-modify-free: bits written 0 SHALL leave OUT unchanged.

Reset
REQ-021 PRESET=1 SHALL asynchronously clear OUT, DIR, IE, MODE, IFG, DBCFG, DBEN, the sync chain, filt, filt_d and counters, forcing gpio_out=0, gpio_oe=0, irq=0 and PSLVERR=0.
REQ-022 Release of reset SHALL produce no IFG set while pins are low; a pin high at release SHALL set IFG in rising/both/level modes once it propagates.
REQ-023 Reset asserted mid-debounce SHALL discard the count.

Structure
REQ-024 Register offsets, MODE encodings and the 32-bit data width SHALL live in shared package gpio_pkg.
REQ-025 The per-pin synchroniser, counter and filter SHALL be sub-module gpio_debounce, instantiated NGPIO times, with T and enable as inputs.

Verification
REQ-026 Write OUT=0x0000_00F0, SET=0x0F, CLR=0x30 -> OUT reads 0x0000_00CF; gpio_out matches.
REQ-027 DBCFG=4, DBEN[0]=1, 3-cycle high pulse on pin 0 -> IN[0] stays 0; a 6-cycle pulse -> IN[0]=1 exactly SYNC_STAGES+4 cycles after the rise.
REQ-028 MODE pin 1=01, IE=0x2, pin 1 falls -> IFG=0x2, irq=1; W1C 0x2 -> IFG=0, irq=0; MODE pin 2=11 with pin 2 held high -> IFG[2] re-sets the cycle after each clear.
REQ-029 W1C IFG bit coincident with a new rising edge on the same pin -> bit reads 1.
REQ-030 Read 0x3C -> PSLVERR=1, PRDATA=0; write IN=0xFFFF_FFFF -> PSLVERR=1, no state change; NGPIO=8 build: write DIR=0xFFFF_FFFF -> reads 0x0000_00FF.
REQ-031 Assert PRESET asynchronously mid-transfer with IFG!=0 -> all outputs 0 immediately; no irq after release with pins low.
